adjust_pingpong_ram: RTL
========================

# adjust_pingpong_ram

Parametrised, double-buffered successor to the 4K×16 adjust-data memory. The host (USB) side writes and reads back a shadow bank while the column-advance logic streams the active bank. A host-requested bank swap takes effect only at a column boundary, so the column currently being applied never sees partially-written adjust data. A built-in read sequencer steps through a programmable number of words per column.

## Interface
- DATA_W, 16, word width, both ports
- ADDR_W, 12, address width; each bank holds 2^ADDR_W words
- READ_LAT, 1, port-B read latency in cycles; legal values 1 or 2; 2 adds an output register
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- wea  in  1  host write enable; writes the shadow bank
- addra  in  ADDR_W  host address for write and readback
- dia  in  DATA_W  host write data
- doa  out  DATA_W  shadow-bank readback of addra; 1-cycle latency
- swap_req  in  1  single-cycle pulse that arms a swap at the next col_start
- swap_pending  out  1  swap armed, not yet applied
- active_bank  out  1  bank currently read by port B
- col_start  in  1  pulse marking a column boundary
- col_adv  in  1  pulse requesting the next word of the column
- col_len  in  ADDR_W  words per column; 0 means 2^ADDR_W; sampled at col_start
- dob  out  DATA_W  active-bank read data
- dob_valid  out  1  dob updated this cycle
- col_done  out  1  coincides with dob_valid of the last word in the column

## Operation
- Banks: shadow = ~active_bank.
  - wea writes dia to shadow[addra].
  - doa returns shadow[addra] registered; it follows active_bank at the edge the address is sampled.
- Swap FSM has two states, IDLE and PENDING.
  - IDLE→PENDING on swap_req.
  - PENDING→IDLE on col_start: active_bank toggles at that edge and swap_pending clears.
  - swap_req while PENDING is absorbed, not counted.
  - swap_req and col_start in the same cycle while IDLE: no swap this boundary; the FSM enters PENDING.
- Write coinciding with the swap edge goes to the pre-swap shadow bank, i.e. the bank that becomes active.
- Sequencer has states STOP and RUN.
  - col_start: ptr←0, len←col_len, state←RUN.
  - col_adv in RUN: read active[ptr], then ptr←ptr+1. The read of index len−1 (or 2^ADDR_W−1 when len=0) is tagged last, and state←STOP.
  - col_adv in STOP is ignored.
  - col_start and col_adv in the same cycle: col_start wins and col_adv is dropped.
  - col_start during RUN restarts the column.
- Reads already issued complete from the bank they were issued against, even across a swap or restart.
- dob holds its last value between valid pulses.
- Pointer arithmetic is ADDR_W+1 bits wide, so len=0 counts the full depth without overflow. ptr never wraps mid-column.

## Timing
- Reset values, applied asynchronously: active_bank=0, swap_pending=0, state=STOP, ptr=0, dob=0, doa=0, dob_valid=0, col_done=0. Memory contents are not reset.
- Reset mid-column aborts the column and discards in-flight reads; no dob_valid follows reset release.
- doa is valid 1 cycle after addra.
- dob and dob_valid follow the accepted col_adv by READ_LAT cycles; col_done asserts in the same cycle as the last dob_valid.
- The swap is visible on active_bank the cycle after col_start. A col_adv in the cycle after col_start reads the new bank.
- Sustained throughput is one col_adv per cycle.
- Write-then-read of the same location: port B sees the new data only after a swap. A port-A read in the cycle following the write returns the new data (write-first).

## Structure
- Package adjust_ram_pkg:
  - typedef for the swap FSM states
  - typedef for the sequencer states
  - READ_LAT legality constant, checked by an elaboration assertion
- Sub-module adjust_bank_ram, instantiated twice: simple dual-port, one write/read port plus one read port, registered read, inferable as block RAM.
- Top level holds the bank-select muxing, the swap FSM, the sequencer and the latency pipeline that carries the bank tag, valid and last.

## Test plan
- Write/readback: write 0xA5A5 to shadow address 0x010, then read addra=0x010 → doa=0xA5A5 one cycle later; active_bank stays 0.
- Swap at boundary: fill shadow with data=addr, pulse swap_req → swap_pending=1. col_start → active_bank=1, pending=0. Then col_len=4 with 4 col_adv → dob 0,1,2,3; col_done with the value 3.
- Full-depth length: ADDR_W=4, col_len=0, 17 col_adv → exactly 16 dob_valid; col_done on the 16th; the 17th is ignored.
- Simultaneous events:
  - col_start+col_adv in the same cycle → no read that cycle.
  - swap_req+col_start while IDLE → pending=1 and no toggle.
  - wea at the swap edge → data lands in the newly active bank.
- In-flight across swap, READ_LAT=2: col_adv then col_start with a pending swap on the next cycle → the first dob still comes from the old bank.
- Reset mid-column: assert rst_n=0 after 2 of 8 reads → all outputs 0 immediately, no late dob_valid; a new col_start after release restarts at address 0.

Source files
------------

// File: rtl/adjust_pingpong_ram_pkg.sv
// Shared types and constants for the double-buffered adjust-data memory.
package adjust_ram_pkg;

  typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t;
  typedef enum logic {SEQ_STOP, SEQ_RUN} seq_state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic bit read_lat_ok(int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/adjust_pingpong_ram_if.sv
// Host, swap and column-stream signals of the adjust memory.
interface adjust_pingpong_ram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dia;
  logic [DATA_W-1:0] doa;
  logic              swap_req;
  logic              swap_pending;
  logic              active_bank;
  logic              col_start;
  logic              col_adv;
  logic [ADDR_W-1:0] col_len;
  logic [DATA_W-1:0] dob;
  logic              dob_valid;
  logic              col_done;

  modport master (
    output wea, addra, dia, swap_req, col_start, col_adv, col_len,
    input  doa, swap_pending, active_bank, dob, dob_valid, col_done
  );

  modport slave (
    input  wea, addra, dia, swap_req, col_start, col_adv, col_len,
    output doa, swap_pending, active_bank, dob, dob_valid, col_done
  );
endinterface

// File: rtl/adjust_pingpong_ram_bank.sv
// One bank: simple dual-port RAM, write/read port A plus read port B,
// both reads registered so the array maps onto block RAM.
module adjust_bank_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout_b
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Port A: write plus registered readback (read-old on same-cycle access)
  always_ff @(posedge clk) begin
    if (we) mem[addr_a] <= din;
    dout_a <= mem[addr_a];
  end

  // Port B: registered read for the column stream
  always_ff @(posedge clk) begin
    dout_b <= mem[addr_b];
  end
endmodule

// File: rtl/adjust_pingpong_ram.sv
// Double-buffered adjust memory: host fills the shadow bank, the column
// sequencer streams the active bank, swaps land only on column boundaries.
module adjust_pingpong_ram
  import adjust_ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adjust_pingpong_ram_if.slave  bus
);
  localparam int CNT_W = ADDR_W + 1;

  if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
    $error("adjust_pingpong_ram: READ_LAT must be 1 or 2");
  end

  swap_state_t swap_q, swap_d;
  seq_state_t  seq_q, seq_d;
  logic        bank_q, toggle;
  logic [CNT_W-1:0] ptr_q, ptr_d, len_q, len_d;
  logic        adv_ok, adv_last;
  logic        sel_a_q, doa_en_q, bank_tag_q;
  logic [READ_LAT:1] vld_pipe, last_pipe;
  logic [1:0]             we;
  logic [1:0][DATA_W-1:0] dout_a, dout_b;
  logic [DATA_W-1:0]      ram_b, dob_q, dob_w;

  // Swap FSM: arm on request, apply on the next column boundary
  always_comb begin
    swap_d = swap_q;
    toggle = 1'b0;
    case (swap_q)
      SWAP_IDLE:    if (bus.swap_req) swap_d = SWAP_PENDING;
      SWAP_PENDING: if (bus.col_start) begin
                      swap_d = SWAP_IDLE;
                      toggle = 1'b1;
                    end
      default:      swap_d = SWAP_IDLE;
    endcase
  end

  // Swap state and active bank registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_q <= SWAP_IDLE;
      bank_q <= 1'b0;
    end else begin
      swap_q <= swap_d;
      if (toggle) bank_q <= ~bank_q;
    end
  end

  // Sequencer: col_start (re)loads and wins over col_adv; len=0 is full depth
  always_comb begin
    seq_d    = seq_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    adv_ok   = 1'b0;
    adv_last = 1'b0;
    if (bus.col_start) begin
      seq_d = SEQ_RUN;
      ptr_d = '0;
      len_d = (bus.col_len == '0) ? (CNT_W'(1) << ADDR_W) : {1'b0, bus.col_len};
    end else if (seq_q == SEQ_RUN && bus.col_adv) begin
      adv_ok   = 1'b1;
      adv_last = (ptr_q + CNT_W'(1)) == len_q;
      ptr_d    = ptr_q + CNT_W'(1);
      if (adv_last) seq_d = SEQ_STOP;
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= SEQ_STOP;
      ptr_q <= '0;
      len_q <= '0;
    end else begin
      seq_q <= seq_d;
      ptr_q <= ptr_d;
      len_q <= len_d;
    end
  end

  // Host writes always target the pre-edge shadow bank
  assign we[0] = bus.wea &  bank_q;
  assign we[1] = bus.wea & ~bank_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    adjust_bank_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk    (clk),
      .we     (we[b]),
      .addr_a (bus.addra),
      .din    (bus.dia),
      .dout_a (dout_a[b]),
      .addr_b (ptr_q[ADDR_W-1:0]),
      .dout_b (dout_b[b])
    );
  end

  // Readback bank is latched with the address; doa forced to 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_a_q  <= 1'b0;
      doa_en_q <= 1'b0;
    end else begin
      sel_a_q  <= ~bank_q;
      doa_en_q <= 1'b1;
    end
  end

  assign bus.doa = doa_en_q ? dout_a[sel_a_q] : '0;

  // Read pipeline: bank tag for the RAM stage, valid/last for all stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      last_pipe  <= '0;
      bank_tag_q <= 1'b0;
    end else begin
      vld_pipe[1]  <= adv_ok;
      last_pipe[1] <= adv_last;
      bank_tag_q   <= bank_q;
      for (int i = 2; i <= READ_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign ram_b = dout_b[bank_tag_q];

  if (READ_LAT == 1) begin : g_lat1
    assign dob_w = vld_pipe[1] ? ram_b : dob_q;
    // Hold register keeps dob stable between valid pulses
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dob_q <= '0;
      else        dob_q <= dob_w;
    end
  end else begin : g_lat2
    assign dob_w = dob_q;
    // Output register captures only valid reads
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           dob_q <= '0;
      else if (vld_pipe[1]) dob_q <= ram_b;
    end
  end

  assign bus.dob          = dob_w;
  assign bus.dob_valid    = vld_pipe[READ_LAT];
  assign bus.col_done     = vld_pipe[READ_LAT] & last_pipe[READ_LAT];
  assign bus.swap_pending = (swap_q == SWAP_PENDING);
  assign bus.active_bank  = bank_q;
endmodule
